// File: rtl/reg_load_sequencer.sv
// Load sequencer: fetches one or two bytes from a byte-wide memory and
// writes them into a 16-bit target register using its function-select port.
// Word loads are little-endian (base -> low half, base+1 -> high half).
module reg_load_sequencer #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] BaseAddr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [7:0]        MemData,
  output logic              RegE,
  output logic [2:0]        RegFunSel,
  output logic [15:0]       RegI,
  output logic              Done,
  output logic              Busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_WORD    = 2'b00,
    MODE_BYTE_ZX = 2'b01,
    MODE_BYTE_SX = 2'b10,
    MODE_BYTE_HI = 2'b11
  } mode_t;

  localparam logic [2:0] FS_RETAIN  = 3'b000;
  localparam logic [2:0] FS_CLR_LO  = 3'b100;
  localparam logic [2:0] FS_WR_HI   = 3'b110;
  localparam logic [2:0] FS_SEXT_LO = 3'b111;

  state_t            state_q, state_d;
  mode_t             mode_q,  mode_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic              accept;

  // State and latched request; reset forces IDLE without waiting for a clock.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_WORD;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
    end
  end

  // Next-state logic and all outputs, decoded from the current state.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    base_d    = base_q;
    ReqReady  = 1'b0;
    MemAddr   = '0;
    MemRead   = 1'b0;
    RegE      = 1'b0;
    RegFunSel = FS_RETAIN;
    RegI      = '0;
    Done      = 1'b0;
    Busy      = (state_q != IDLE);
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        ReqReady = ~Reset;
        accept   = ReqValid & ~Reset;
        if (accept) begin
          state_d = RD_LO;
          mode_d  = mode_t'(Mode);
          base_d  = BaseAddr;
        end
      end
      RD_LO: begin
        MemAddr = base_q;
        MemRead = 1'b1;
        state_d = WR_LO;
      end
      WR_LO: begin
        RegE = 1'b1;
        RegI = {8'h00, MemData};
        case (mode_q)
          MODE_BYTE_SX: RegFunSel = FS_SEXT_LO;
          MODE_BYTE_HI: RegFunSel = FS_WR_HI;
          default:      RegFunSel = FS_CLR_LO;
        endcase
        // The high-byte read overlaps the low-byte write.
        if (mode_q == MODE_WORD) begin
          MemAddr = base_q + ADDR_W'(1);
          MemRead = 1'b1;
          state_d = WR_HI;
        end else begin
          state_d = DONE;
        end
      end
      WR_HI: begin
        RegE      = 1'b1;
        RegFunSel = FS_WR_HI;
        RegI      = {8'h00, MemData};
        state_d   = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
